// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-memory loader.
// With IM_LOADER_CKSUM_EN defined, the state enum gains ST_CKSUM.
package cpu_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         IM_DEPTH  = 1024;
  localparam int         IM_AW     = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
`ifdef IM_LOADER_CKSUM_EN
    ST_CKSUM,
`endif
    ST_FIN
  } state_t;

  // A frame must carry at least one word and fit the instruction memory.
  function automatic logic len_ok(input logic [15:0] n);
    return (n != 16'd0) && (n <= 16'(IM_DEPTH));
  endfunction

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The host (master) drives bytes; the loader (slave) drives the memory port.
interface im_loader_if;
  logic [7:0]                in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic                      im_we;
  logic [cpu_pkg::IM_AW-1:0] im_waddr;
  logic [31:0]               im_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, im_we, im_waddr, im_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, im_we, im_waddr, im_wdata
  );
endinterface

// File: rtl/im_word_asm.sv
// Byte-to-word shift register: packs four bytes big-endian into one word.
// last_o flags the byte that completes a word; word_o is valid the next cycle.
module im_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        last_o
);

  logic [1:0]  cnt_q;
  logic [31:0] word_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
    end else if (byte_vld_i) begin
      word_q <= {word_q[23:0], byte_i};
      cnt_q  <= cnt_q + 2'd1;
    end
  end

  assign last_o = byte_vld_i && (cnt_q == 2'd3);
  assign word_o = word_q;

endmodule

// File: rtl/im_loader.sv
// Serial-frame loader: sync, 16-bit word count, data words -> instruction memory.
// Define IM_LOADER_CKSUM_EN to require a trailing XOR checksum byte.
module im_loader
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  im_loader_if.slave   bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         err
);

  state_t      state_q;
  logic        we_q, cpu_hold_q, done_q, err_q, len_ph_q;
  logic [7:0]  len_hi_q;
  logic [10:0] len_q, cnt_q, cnt_inc;
  logic [15:0] len_full;
  logic        accept, last_byte;
  logic [31:0] word;
`ifdef IM_LOADER_CKSUM_EN
  logic [7:0]  xor_q;
`endif

  // Ready drops during the write cycle so the next byte waits for the new word slot.
  assign bus.in_ready = !rst && !we_q && (state_q != ST_FIN);
  assign accept       = bus.in_valid && bus.in_ready;
  assign cnt_inc      = cnt_q + 11'd1;
  assign len_full     = {len_hi_q, bus.in_data};

  im_word_asm u_asm (
    .clk        (clk),
    .rst        (rst),
    .byte_vld_i (accept && (state_q == ST_DATA)),
    .byte_i     (bus.in_data),
    .word_o     (word),
    .last_o     (last_byte)
  );

  assign bus.im_we    = we_q && !rst;
  assign bus.im_waddr = cnt_q[IM_AW-1:0];
  assign bus.im_wdata = word;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign err          = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      len_ph_q   <= 1'b0;
      len_hi_q   <= 8'd0;
      len_q      <= 11'd0;
      cnt_q      <= 11'd0;
`ifdef IM_LOADER_CKSUM_EN
      xor_q      <= 8'd0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cpu_hold_q <= 1'b0;
          if (accept && (bus.in_data == SYNC_BYTE)) begin
            state_q    <= ST_LEN;
            cpu_hold_q <= 1'b1;
            err_q      <= 1'b0;
            len_ph_q   <= 1'b0;
            cnt_q      <= 11'd0;
`ifdef IM_LOADER_CKSUM_EN
            xor_q      <= 8'd0;
`endif
          end
        end
        ST_LEN: begin
          if (accept) begin
            if (!len_ph_q) begin
              len_hi_q <= bus.in_data;
              len_ph_q <= 1'b1;
            end else if (len_ok(len_full)) begin
              len_q   <= len_full[10:0];
              state_q <= ST_DATA;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          // The 11-bit count reaches N = 1024 without wrapping.
          if (we_q) begin
            we_q  <= 1'b0;
            cnt_q <= cnt_inc;
            if (cnt_inc == len_q) begin
`ifdef IM_LOADER_CKSUM_EN
              state_q <= ST_CKSUM;
`else
              state_q <= ST_FIN;
              done_q  <= 1'b1;
`endif
            end
          end else if (accept) begin
`ifdef IM_LOADER_CKSUM_EN
            xor_q <= xor_q ^ bus.in_data;
`endif
            if (last_byte) we_q <= 1'b1;
          end
        end
`ifdef IM_LOADER_CKSUM_EN
        ST_CKSUM: begin
          if (accept) begin
            if (bus.in_data == xor_q) begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
`endif
        ST_FIN: begin
          cpu_hold_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
